// File: rtl/fft8_stream.sv
// Streaming 8-point radix-2 DIF FFT: one {re,im} sample in and one natural-order bin out per clock, out = DFT/8.
// Define FFT_ROUND_EN to round half-up at every >>>1 and >>>10 instead of truncating.
module fft8_stream #(
  parameter int DW = 12,
  parameter int CW = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2*DW-1:0] in,
  output logic [2*DW-1:0] out
);

  localparam int FRAC = 10;
  localparam logic signed [CW-1:0] C707 = CW'(32'sd724);
  localparam logic signed [CW-1:0] N707 = CW'(-32'sd724);

  logic [2:0]           cnt_q, cnt_d;
  logic                 cb_q, cb_d;
  logic [2*DW-1:0]      coll_q [0:1][0:7];
  logic [2*DW-1:0]      coll_d [0:1][0:7];
  logic signed [DW-1:0] xre [0:7];
  logic signed [DW-1:0] xim [0:7];
  logic signed [DW-1:0] s1r_q [0:7];
  logic signed [DW-1:0] s1i_q [0:7];
  logic signed [DW-1:0] s1r_d [0:7];
  logic signed [DW-1:0] s1i_d [0:7];
  logic signed [DW-1:0] s2r_q [0:7];
  logic signed [DW-1:0] s2i_q [0:7];
  logic signed [DW-1:0] s2r_d [0:7];
  logic signed [DW-1:0] s2i_d [0:7];
  logic                 v1_q, v1_d, v2_q, v2_d;
  logic [2*DW-1:0]      obuf_q [0:1][0:7];
  logic [2*DW-1:0]      obuf_d [0:1][0:7];
  logic                 wb_q, wb_d, rb_q, rb_d, ract_q, ract_d;
  logic [2:0]           ridx_q, ridx_d;
  logic [2*DW-1:0]      out_q, out_d;

  // (a +/- b) >>> 1 evaluated at DW+1 bits so the sum itself never overflows
  function automatic logic signed [DW-1:0] hadd(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b,
                                                 input logic sub);
    logic signed [DW:0] ea, eb, s;
    ea = {a[DW-1], a};
    eb = {b[DW-1], b};
    if (sub) begin
      s = ea - eb;
    end else begin
      s = ea + eb;
    end
`ifdef FFT_ROUND_EN
    s = s + {{DW{1'b0}}, 1'b1};
`endif
    return s[DW:1];
  endfunction

  function automatic logic [2*DW-1:0] cmul(input logic signed [DW-1:0] br,
                                           input logic signed [DW-1:0] bi,
                                           input logic signed [CW-1:0] wr,
                                           input logic signed [CW-1:0] wi);
    logic signed [DW+CW:0] ebr, ebi, ewr, ewi, pr, pi, rnd;
    ebr = {{(CW+1){br[DW-1]}}, br};
    ebi = {{(CW+1){bi[DW-1]}}, bi};
    ewr = {{(DW+1){wr[CW-1]}}, wr};
    ewi = {{(DW+1){wi[CW-1]}}, wi};
    rnd = '0;
`ifdef FFT_ROUND_EN
    rnd[FRAC-1] = 1'b1;
`endif
    pr = ebr * ewr - ebi * ewi + rnd;
    pi = ebr * ewi + ebi * ewr + rnd;
    return {pr[FRAC+DW-1:FRAC], pi[FRAC+DW-1:FRAC]};
  endfunction

  // W8^k rotation; k = 0 and k = 2 are exact and bypass the multiplier
  function automatic logic [2*DW-1:0] rot(input logic signed [DW-1:0] br,
                                          input logic signed [DW-1:0] bi,
                                          input logic [1:0] k);
    logic signed [DW-1:0] nr;
    logic [2*DW-1:0]      res;
    nr = -br;
    case (k)
      2'd0:    res = {br, bi};
      2'd1:    res = cmul(br, bi, C707, N707);
      2'd2:    res = {bi, nr};
      2'd3:    res = cmul(br, bi, N707, N707);
      default: res = {br, bi};
    endcase
    return res;
  endfunction

  function automatic logic [2:0] brev(input logic [2:0] p);
    return {p[0], p[1], p[2]};
  endfunction

  // Sample counter and ping-pong input collector
  always_comb begin
    coll_d = coll_q;
    coll_d[cb_q][cnt_q] = in;
    cnt_d = cnt_q + 3'd1;
    if (cnt_q == 3'd7) begin
      cb_d = ~cb_q;
    end else begin
      cb_d = cb_q;
    end
  end

  // Stage-1 operands: x7 is taken straight from the input as it arrives
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      if (n == 7) begin
        xre[n] = in[2*DW-1:DW];
        xim[n] = in[DW-1:0];
      end else begin
        xre[n] = coll_q[cb_q][n][2*DW-1:DW];
        xim[n] = coll_q[cb_q][n][DW-1:0];
      end
    end
  end

  // Stage 1: pairs (n, n+4), twiddle W8^n
  always_comb begin : stage1
    logic signed [DW-1:0] dr, di;
    logic [2*DW-1:0]      t;
    dr = '0;
    di = '0;
    t  = '0;
    s1r_d = s1r_q;
    s1i_d = s1i_q;
    v1_d  = (cnt_q == 3'd7);
    if (cnt_q == 3'd7) begin
      for (int n = 0; n < 4; n++) begin
        s1r_d[n] = hadd(xre[n], xre[n+4], 1'b0);
        s1i_d[n] = hadd(xim[n], xim[n+4], 1'b0);
        dr = hadd(xre[n], xre[n+4], 1'b1);
        di = hadd(xim[n], xim[n+4], 1'b1);
        t  = rot(dr, di, 2'(n));
        s1r_d[n+4] = t[2*DW-1:DW];
        s1i_d[n+4] = t[DW-1:0];
      end
    end else begin
      s1r_d = s1r_q;
      s1i_d = s1i_q;
    end
  end

  // Stage 2: pairs (i, i+2) inside each half, twiddle W8^(2j)
  always_comb begin : stage2
    logic signed [DW-1:0] dr, di;
    logic [2*DW-1:0]      t;
    int                   i0;
    dr = '0;
    di = '0;
    t  = '0;
    i0 = 0;
    s2r_d = s2r_q;
    s2i_d = s2i_q;
    v2_d  = v1_q;
    if (v1_q) begin
      for (int h = 0; h < 2; h++) begin
        for (int j = 0; j < 2; j++) begin
          i0 = 4 * h + j;
          s2r_d[i0] = hadd(s1r_q[i0], s1r_q[i0+2], 1'b0);
          s2i_d[i0] = hadd(s1i_q[i0], s1i_q[i0+2], 1'b0);
          dr = hadd(s1r_q[i0], s1r_q[i0+2], 1'b1);
          di = hadd(s1i_q[i0], s1i_q[i0+2], 1'b1);
          t  = rot(dr, di, 2'(2 * j));
          s2r_d[i0+2] = t[2*DW-1:DW];
          s2i_d[i0+2] = t[DW-1:0];
        end
      end
    end else begin
      s2r_d = s2r_q;
      s2i_d = s2i_q;
    end
  end

  // Stage 3 writes bins straight into the output bank at bit-reversed addresses
  always_comb begin
    obuf_d = obuf_q;
    if (v2_q) begin
      for (int p = 0; p < 4; p++) begin
        obuf_d[wb_q][brev(3'(2 * p))] =
          {hadd(s2r_q[2*p], s2r_q[2*p+1], 1'b0), hadd(s2i_q[2*p], s2i_q[2*p+1], 1'b0)};
        obuf_d[wb_q][brev(3'(2 * p + 1))] =
          {hadd(s2r_q[2*p], s2r_q[2*p+1], 1'b1), hadd(s2i_q[2*p], s2i_q[2*p+1], 1'b1)};
      end
    end else begin
      obuf_d = obuf_q;
    end
  end

  // Natural-order readout; a freshly written bank takes over on the cycle after it is filled
  always_comb begin
    if (v2_q) begin
      rb_d   = wb_q;
      wb_d   = ~wb_q;
      ridx_d = 3'd0;
      ract_d = 1'b1;
    end else begin
      rb_d   = rb_q;
      wb_d   = wb_q;
      ract_d = ract_q;
      if (ract_q) begin
        ridx_d = ridx_q + 3'd1;
      end else begin
        ridx_d = ridx_q;
      end
    end
    if (ract_q) begin
      out_d = obuf_q[rb_q][ridx_q];
    end else begin
      out_d = out_q;
    end
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= 3'd0;
      cb_q   <= 1'b0;
      coll_q <= '{default: '0};
      s1r_q  <= '{default: '0};
      s1i_q  <= '{default: '0};
      s2r_q  <= '{default: '0};
      s2i_q  <= '{default: '0};
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      obuf_q <= '{default: '0};
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
      ridx_q <= 3'd0;
      ract_q <= 1'b0;
      out_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      cb_q   <= cb_d;
      coll_q <= coll_d;
      s1r_q  <= s1r_d;
      s1i_q  <= s1i_d;
      s2r_q  <= s2r_d;
      s2i_q  <= s2i_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      obuf_q <= obuf_d;
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      ridx_q <= ridx_d;
      ract_q <= ract_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_fft8_stream.sv
// Directed-vector bench for fft8_stream: hand-computed blocks, a random stream against a loop-based DFT model, and mid-block reset.
module tb_fft8_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] din;
  logic [23:0] dout;

  fft8_stream #(.DW(12), .CW(12)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (din),
    .out   (dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] x [0:7];
    logic [23:0] y [0:7];
  } vec_t;

  localparam int NTBL = 5;
  localparam int NRND = 128;

  vec_t        tbl  [0:NTBL-1];
  logic [23:0] stim [0:2047];
  logic [23:0] expv [0:2047];
  int          n_chk = 0;
  int          n_err = 0;

  function automatic logic [23:0] pk(input int re, input int im);
    logic [11:0] a, b;
    a = re[11:0];
    b = im[11:0];
    return {a, b};
  endfunction

  function automatic int sx(input logic [11:0] v);
    logic signed [11:0] t;
    t = v;
    return int'(t);
  endfunction

  function automatic int wrapw(input int v);
    return sx(v[11:0]);
  endfunction

  function automatic int brv(input int p);
    return ((p & 1) << 2) | (p & 2) | ((p >> 2) & 1);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [23:0] act, input logic [23:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s[%0d]: got (%0d,%0d) want (%0d,%0d)", nm, idx,
               sx(act[23:12]), sx(act[11:0]), sx(want[23:12]), sx(want[11:0]));
    end
  endtask

  // Straight DIF model: spans 4,2,1 with twiddle W8^(j*8/(2*span)), general multiply for every twiddle
  task automatic model_block(input int base);
    int vr [0:7];
    int vi [0:7];
    int wr [0:3];
    int wi [0:3];
    int span, i1, k, ar, ai, dr, di;
    wr = '{1024, 724, 0, -724};
    wi = '{0, -724, -1024, -724};
    for (int i = 0; i < 8; i++) begin
      vr[i] = sx(stim[base+i][23:12]);
      vi[i] = sx(stim[base+i][11:0]);
    end
    for (int st = 0; st < 3; st++) begin
      span = 4 >> st;
      for (int i0 = 0; i0 < 8; i0++) begin
        if ((i0 & span) == 0) begin
          i1 = i0 + span;
          k  = (i0 % span) * (4 / span);
          ar = (vr[i0] + vr[i1]) >>> 1;
          ai = (vi[i0] + vi[i1]) >>> 1;
          dr = (vr[i0] - vr[i1]) >>> 1;
          di = (vi[i0] - vi[i1]) >>> 1;
          vr[i0] = ar;
          vi[i0] = ai;
          vr[i1] = wrapw((dr * wr[k] - di * wi[k]) >>> 10);
          vi[i1] = wrapw((dr * wi[k] + di * wr[k]) >>> 10);
        end
      end
    end
    for (int p = 0; p < 8; p++) begin
      expv[base + brv(p)] = pk(vr[p], vi[p]);
    end
  endtask

  // Drive n_samp samples back-to-back; out must be 0 for 10 edges, then follow expv
  task automatic run(input int n_samp, input int n_exp);
    for (int e = 0; e < n_samp + 10; e++) begin
      din = (e < n_samp) ? stim[e] : 24'd0;
      @(posedge clk);
      @(negedge clk);
      if (e < 10) begin
        chk("lead0", e, dout, 24'd0);
      end else if (e - 10 < n_exp) begin
        chk("bin", e - 10, dout, expv[e-10]);
      end
    end
  endtask

  initial begin
    for (int v = 0; v < NTBL; v++) begin
      for (int i = 0; i < 8; i++) begin
        tbl[v].x[i] = 24'd0;
        tbl[v].y[i] = 24'd0;
      end
    end
    // real impulse
    tbl[0].x[0] = pk(256, 0);
    for (int i = 0; i < 8; i++) tbl[0].y[i] = pk(32, 0);
    // DC
    for (int i = 0; i < 8; i++) tbl[1].x[i] = pk(256, 0);
    tbl[1].y[0] = pk(256, 0);
    // alternating
    for (int i = 0; i < 8; i++) tbl[2].x[i] = pk((i % 2 == 0) ? 256 : -256, 0);
    tbl[2].y[4] = pk(256, 0);
    // imaginary impulse
    tbl[3].x[0] = pk(0, -256);
    for (int i = 0; i < 8; i++) tbl[3].y[i] = pk(0, -32);
    // impulse at x1 exercises the W^1/W^3 multiplies and their truncation
    tbl[4].x[1] = pk(256, 0);
    tbl[4].y[0] = pk(32, 0);
    tbl[4].y[1] = pk(22, -23);
    tbl[4].y[2] = pk(0, -32);
    tbl[4].y[3] = pk(-23, -23);
    tbl[4].y[4] = pk(-32, 0);
    tbl[4].y[5] = pk(-23, 23);
    tbl[4].y[6] = pk(0, 32);
    tbl[4].y[7] = pk(23, 22);

    for (int v = 0; v < NTBL; v++) begin
      for (int i = 0; i < 8; i++) begin
        stim[8*v+i] = tbl[v].x[i];
        expv[8*v+i] = tbl[v].y[i];
      end
    end
    for (int b = NTBL; b < NTBL + NRND; b++) begin
      for (int i = 0; i < 8; i++) stim[8*b+i] = 24'($urandom());
      model_block(8 * b);
    end

    reset = 1'b1;
    din   = 24'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", 0, dout, 24'd0);
    reset = 1'b0;
    run(8 * (NTBL + NRND), 8 * (NTBL + NRND));

    // Mid-block reset: impulse block then x0..x3 of the next one
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int e = 0; e < 12; e++) begin
      din = (e % 8 == 0) ? pk(256, 0) : 24'd0;
      @(posedge clk);
      @(negedge clk);
    end
    chk("pre_rst", 11, dout, pk(32, 0));
    reset = 1'b1;
    #1;
    chk("async_rst", 0, dout, 24'd0);
    @(posedge clk);
    @(negedge clk);
    chk("held_rst", 0, dout, 24'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      stim[i] = pk(256, 0);
      expv[i] = (i == 0) ? pk(256, 0) : 24'd0;
    end
    run(8, 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
